// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode constants and the per-port response capture rule.
package alu_pkg;

  localparam int ALU_W    = 32;
  localparam int ALU_OP_W = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 4'b0000;
  localparam alu_op_t ALU_AND = 4'b0001;
  localparam alu_op_t ALU_OR  = 4'b0010;
  localparam alu_op_t ALU_SLL = 4'b0011;
  localparam alu_op_t ALU_SLT = 4'b0100;
  localparam alu_op_t ALU_SRL = 4'b0101;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_XOR = 4'b0111;
  localparam alu_op_t ALU_BEQ = 4'b1000;
  localparam alu_op_t ALU_BNE = 4'b1001;

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;
  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             zero;
  } rsp_t;

  // Arithmetic ops keep the result, branches keep only the flag, everything else yields zeros.
  function automatic rsp_t capture(alu_op_t op, logic [ALU_W-1:0] result, logic zero);
    rsp_t r;
    r.result = '0;
    r.zero   = 1'b0;
    if (!op[ALU_OP_W-1]) r.result = result;
    else if (op == ALU_BEQ || op == ALU_BNE) r.zero = zero;
    return r;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle for both client ports of the shared ALU controller.
interface alu_share_ctrl_if;
  import alu_pkg::*;

  logic             req0_valid, req0_ready;
  logic [ALU_W-1:0] req0_r1, req0_r2;
  alu_op_t          req0_control;
  logic             rsp0_valid, rsp0_ready;
  logic [ALU_W-1:0] rsp0_result;
  logic             rsp0_zero;

  logic             req1_valid, req1_ready;
  logic [ALU_W-1:0] req1_r1, req1_r2;
  alu_op_t          req1_control;
  logic             rsp1_valid, rsp1_ready;
  logic [ALU_W-1:0] rsp1_result;
  logic             rsp1_zero;

  logic             busy;

  modport master (
    output req0_valid, req0_r1, req0_r2, req0_control, rsp0_ready,
    output req1_valid, req1_r1, req1_r2, req1_control, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero, busy
  );

  modport slave (
    input  req0_valid, req0_r1, req0_r2, req0_control, rsp0_ready,
    input  req1_valid, req1_r1, req1_r2, req1_control, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero, busy
  );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU; zero reports equality for BEQ, inequality for BNE.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] r1,
  input  logic [ALU_W-1:0] r2,
  input  alu_op_t          control,
  output logic [ALU_W-1:0] result,
  output logic             zero
);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    result = '0;
    case (control)
      ALU_ADD: result = r1 + r2;
      ALU_AND: result = r1 & r2;
      ALU_OR:  result = r1 | r2;
      ALU_SLL: result = r1 << r2[4:0];
      ALU_SLT: result = {{(ALU_W-1){1'b0}}, $signed(r1) < $signed(r2)};
      ALU_SRL: result = r1 >> r2[4:0];
      ALU_SUB: result = r1 - r2;
      ALU_XOR: result = r1 ^ r2;
      ALU_BEQ: result = r1 - r2;
      ALU_BNE: result = r1 - r2;
      default: result = '0;
    endcase
    zero = (control == ALU_BNE) ? (result != '0) : (result == '0);
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one ALU between two clients, with a registered response slot per port.
module alu_share_ctrl
  import alu_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  alu_share_ctrl_if.slave bus
);

  slot_e            slot0, slot1, slot0_nxt, slot1_nxt;
  port_e            last_grant;
  rsp_t             rsp0, rsp1, captured;
  logic             busy_q;
  logic             elig0, elig1, grant0, grant1;
  logic [ALU_W-1:0] alu_r1, alu_r2, alu_result;
  alu_op_t          alu_control;
  logic             alu_zero;

  // A full slot still accepts a new request when it is being drained in the same cycle.
  assign elig0  = bus.req0_valid && (slot0 == SLOT_EMPTY || bus.rsp0_ready);
  assign elig1  = bus.req1_valid && (slot1 == SLOT_EMPTY || bus.rsp1_ready);
  assign grant0 = rst_n && elig0 && (!elig1 || last_grant == PORT1);
  assign grant1 = rst_n && elig1 && (!elig0 || last_grant == PORT0);

  assign alu_r1      = grant1 ? bus.req1_r1      : bus.req0_r1;
  assign alu_r2      = grant1 ? bus.req1_r2      : bus.req0_r2;
  assign alu_control = grant1 ? bus.req1_control : bus.req0_control;

  alu u_alu (
    .r1      (alu_r1),
    .r2      (alu_r2),
    .control (alu_control),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  assign captured = capture(alu_control, alu_result, alu_zero);

  always_comb begin
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    if (grant0)              slot0_nxt = SLOT_FULL;
    else if (bus.rsp0_ready) slot0_nxt = SLOT_EMPTY;
    if (grant1)              slot1_nxt = SLOT_FULL;
    else if (bus.rsp1_ready) slot1_nxt = SLOT_EMPTY;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0      <= SLOT_EMPTY;
      slot1      <= SLOT_EMPTY;
      rsp0       <= '0;
      rsp1       <= '0;
      last_grant <= PORT1;
      busy_q     <= 1'b0;
    end else begin
      slot0  <= slot0_nxt;
      slot1  <= slot1_nxt;
      busy_q <= (slot0_nxt == SLOT_FULL) || (slot1_nxt == SLOT_FULL);
      if (grant0) rsp0 <= captured;
      if (grant1) rsp1 <= captured;
      if (grant0)      last_grant <= PORT0;
      else if (grant1) last_grant <= PORT1;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rsp0_valid  = (slot0 == SLOT_FULL);
  assign bus.rsp1_valid  = (slot1 == SLOT_FULL);
  assign bus.rsp0_result = rsp0.result;
  assign bus.rsp1_result = rsp1.result;
  assign bus.rsp0_zero   = rsp0.zero;
  assign bus.rsp1_zero   = rsp1.zero;
  assign bus.busy        = busy_q;

endmodule
